// File: rtl/bcd_to_bin_seq.sv
// bcd_to_bin_seq
// Sequential BCD-to-binary converter. It takes three BCD digits
// (hundreds, tens, units) and rebuilds the binary value by reverse
// double-dabble, with one shift/correct iteration per clock. Digits above 9
// are reported on error. Values above 255 are reported on overflow, and
// bin_out then carries the low 8 bits of the value.
//
// Ports:
//   clk          in   1  clock, rising edge
//   reset        in   1  synchronous, active-high reset
//   start        in   1  conversion request, only looked at while idle
//   bcd_hundreds in   4  hundreds digit
//   bcd_tens     in   4  tens digit
//   bcd_units    in   4  units digit
//   busy         out  1  high while the shift iterations run
//   done         out  1  single-cycle pulse when results/flags update
//   bin_out      out  8  low 8 bits of the decoded value
//   error        out  1  a latched digit was above 9
//   overflow     out  1  decoded value was above 255
module bcd_to_bin_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] bcd_hundreds,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_units,
  output logic       busy,
  output logic       done,
  output logic [7:0] bin_out,
  output logic       error,
  output logic       overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // The last iteration is the one that runs while the counter reads 9,
  // which gives ten iterations in total. Ten iterations cover every value
  // from 0 to 999.
  localparam logic [3:0] LAST_ITER = 4'd9;

  state_t      state_q, state_d;
  logic [11:0] bcd_q, bcd_d;
  logic [9:0]  bin_q, bin_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  binOut_q, binOut_d;
  logic        error_q, error_d;
  logic        overflow_q, overflow_d;

  logic        digitInvalid;
  logic [21:0] shifted;
  logic [11:0] corrected;

  // Reverse double-dabble correction. After the right shift, a nibble that
  // is 8 or more received a 1 from the digit above it. That 1 is worth 10
  // in decimal, and the shift halves it to 5. The shift placed 8 in the
  // nibble, so subtracting 3 leaves the correct 5.
  function automatic logic [3:0] adjustNibble(input logic [3:0] nib);
    adjustNibble = (nib >= 4'd8) ? (nib - 4'd3) : nib;
  endfunction

  // One datapath step: shift {bcd, bin} right by one, then correct each
  // BCD nibble of the shifted value.
  always_comb begin
    shifted   = {bcd_q, bin_q} >> 1;
    corrected = {adjustNibble(shifted[21:18]),
                 adjustNibble(shifted[17:14]),
                 adjustNibble(shifted[13:10])};
  end

  assign digitInvalid = (bcd_hundreds > 4'd9) || (bcd_tens > 4'd9) ||
                        (bcd_units > 4'd9);

  // Next-state logic. Every register holds its value unless the current
  // state says otherwise, so the results stay stable between DONE pulses.
  always_comb begin
    state_d    = state_q;
    bcd_d      = bcd_q;
    bin_d      = bin_q;
    cnt_d      = cnt_q;
    binOut_d   = binOut_q;
    error_d    = error_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (digitInvalid) begin
            // No iterations are needed. Report the error at once.
            error_d    = 1'b1;
            overflow_d = 1'b0;
            binOut_d   = 8'd0;
            state_d    = DONE;
          end else begin
            bcd_d   = {bcd_hundreds, bcd_tens, bcd_units};
            bin_d   = 10'd0;
            cnt_d   = 4'd0;
            state_d = SHIFT;
          end
        end
      end

      SHIFT: begin
        bcd_d = corrected;
        bin_d = shifted[9:0];
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == LAST_ITER) begin
          binOut_d   = shifted[7:0];
          overflow_d = |shifted[9:8];
          error_d    = 1'b0;
          cnt_d      = 4'd0;
          state_d    = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset is synchronous, so an aborted
  // conversion returns to the reset values at the next edge without
  // producing a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      bcd_q      <= 12'd0;
      bin_q      <= 10'd0;
      cnt_q      <= 4'd0;
      binOut_q   <= 8'd0;
      error_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bcd_q      <= bcd_d;
      bin_q      <= bin_d;
      cnt_q      <= cnt_d;
      binOut_q   <= binOut_d;
      error_q    <= error_d;
      overflow_q <= overflow_d;
    end
  end

  // busy and done are decoded only from the state register. They therefore
  // have no combinational path from any input.
  assign busy     = (state_q == SHIFT);
  assign done     = (state_q == DONE);
  assign bin_out  = binOut_q;
  assign error    = error_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// Testbench for bcd_to_bin_seq. The expected results come from plain
// decimal arithmetic on the digits: value = 100*h + 10*t + u. Any digit
// above 9 gives an error result.
module tb_bcd_to_bin_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] bcd_hundreds;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic       busy;
  logic       done;
  logic [7:0] bin_out;
  logic       error;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_seq dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bcd_hundreds (bcd_hundreds),
    .bcd_tens     (bcd_tens),
    .bcd_units    (bcd_units),
    .busy         (busy),
    .done         (done),
    .bin_out      (bin_out),
    .error        (error),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  // Watchdog that stops a run which never finishes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] h, input logic [3:0] t,
                               input logic [3:0] u, input logic s);
    bcd_hundreds = h;
    bcd_tens     = t;
    bcd_units    = u;
    start        = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Full conversion. The task is called in an IDLE cycle. It returns in the
  // cycle after done, which is the next IDLE cycle.
  task automatic runConv(input logic [3:0] h, input logic [3:0] t,
                         input logic [3:0] u);
    int    cycles;
    int    busyCnt;
    int    value;
    logic  expErr;
    logic  expOvf;
    logic [7:0] expBin;
    string tag;
    tag    = $sformatf("conv%0h%0h%0h", h, t, u);
    value  = 100 * int'(h) + 10 * int'(t) + int'(u);
    expErr = (h > 4'd9) || (t > 4'd9) || (u > 4'd9);
    expOvf = !expErr && (value > 255);
    expBin = expErr ? 8'd0 : 8'(value % 256);

    applyStimulus(h, t, u, 1'b1);
    tick();
    applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);
    cycles  = 1;
    busyCnt = 0;
    while (done !== 1'b1 && cycles < 30) begin
      if (busy === 1'b1) busyCnt++;
      tick();
      cycles++;
    end
    checkOutput({tag, ".latency"}, cycles, expErr ? 1 : 11);
    checkOutput({tag, ".busyCycles"}, busyCnt, expErr ? 0 : 10);
    checkOutput({tag, ".busyAtDone"}, {31'd0, busy}, 0);
    checkOutput({tag, ".binOut"}, {24'd0, bin_out}, {24'd0, expBin});
    checkOutput({tag, ".error"}, {31'd0, error}, {31'd0, expErr});
    checkOutput({tag, ".overflow"}, {31'd0, overflow}, {31'd0, expOvf});
    if (!expErr) checkOutput({tag, ".residue"}, {20'd0, dut.bcd_q}, 0);
    tick();
    checkOutput({tag, ".donePulse"}, {31'd0, done}, 0);
  endtask

  initial begin
    int doneCnt;
    int gap;
    applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    checkOutput("reset.busy", {31'd0, busy}, 0);
    checkOutput("reset.done", {31'd0, done}, 0);
    checkOutput("reset.binOut", {24'd0, bin_out}, 0);
    checkOutput("reset.error", {31'd0, error}, 0);
    checkOutput("reset.overflow", {31'd0, overflow}, 0);
    reset = 1'b0;
    tick();

    // Directed conversions.
    runConv(4'd2, 4'd5, 4'd5);
    runConv(4'd9, 4'd9, 4'd9);
    runConv(4'd1, 4'd0, 4'd0);
    runConv(4'd0, 4'd0, 4'd0);
    runConv(4'd1, 4'hA, 4'd3);
    runConv(4'd0, 4'd4, 4'd2);

    // start held high: conversions complete at T+11 and T+23.
    applyStimulus(4'd1, 4'd2, 4'd8, 1'b1);
    tick();
    doneCnt = 0;
    for (int c = 1; c <= 23; c++) begin
      if (done === 1'b1) begin
        doneCnt++;
        checkOutput($sformatf("held.doneCycle%0d", c), c, (doneCnt == 1) ? 11 : 23);
        checkOutput("held.binOut", {24'd0, bin_out}, 32'h80);
      end
      if (c < 23) tick();
    end
    checkOutput("held.doneCount", doneCnt, 2);
    applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);
    tick();

    // start and digits change during SHIFT and DONE. These changes must be
    // ignored.
    applyStimulus(4'd1, 4'd2, 4'd8, 1'b1);
    tick();
    doneCnt = 0;
    for (int c = 1; c <= 14; c++) begin
      if (done === 1'b1) begin
        doneCnt++;
        checkOutput("mid.doneCycle", c, 11);
        checkOutput("mid.binOut", {24'd0, bin_out}, 32'h80);
      end
      if (c <= 11) applyStimulus(4'($urandom_range(0, 15)), 4'd9, 4'd9, c[0]);
      else applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);
      if (c == 11) applyStimulus(4'd3, 4'd3, 4'd3, 1'b1);
      if (c == 13) checkOutput("mid.noRestart", {31'd0, busy}, 0);
      tick();
    end
    checkOutput("mid.doneCount", doneCnt, 1);

    // Reset during a conversion.
    runConv(4'd9, 4'd9, 4'd9);
    applyStimulus(4'd9, 4'd9, 4'd9, 1'b1);
    tick();
    applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);
    for (int c = 1; c < 5; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("abort.busy", {31'd0, busy}, 0);
    checkOutput("abort.done", {31'd0, done}, 0);
    checkOutput("abort.binOut", {24'd0, bin_out}, 0);
    checkOutput("abort.overflow", {31'd0, overflow}, 0);
    checkOutput("abort.error", {31'd0, error}, 0);
    doneCnt = 0;
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) doneCnt++;
      tick();
    end
    checkOutput("abort.noDone", doneCnt, 0);
    runConv(4'd0, 4'd0, 4'd7);

    // reset and start in the same cycle: reset takes priority.
    applyStimulus(4'd1, 4'd2, 4'd3, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    applyStimulus(4'd0, 4'd0, 4'd0, 1'b0);
    tick();
    checkOutput("resetStart.busy", {31'd0, busy}, 0);
    checkOutput("resetStart.done", {31'd0, done}, 0);

    // Sweep of every value from 0 to 999, with random gaps between
    // conversions.
    for (int v = 0; v < 1000; v++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) tick();
      runConv(4'(v / 100), 4'((v / 10) % 10), 4'(v % 10));
    end

    // Random digits, including some invalid ones.
    for (int n = 0; n < 150; n++) begin
      runConv(4'($urandom_range(0, 11)), 4'($urandom_range(0, 11)),
              4'($urandom_range(0, 11)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
